// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the timer run controller.
package timer_ctrl_pkg;

  localparam int TIMER_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_cnt.sv
// Up-counter datapath for timer_ctrl: clear wins over enable, sync active-low reset.
module timer_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)    r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  assign o_q = r_q;

endmodule

// File: rtl/timer_ctrl.sv
// Run controller (FSM, compare, done/err pulses) around timer_cnt.
// Define TIMER_CTRL_FORMAL_EN to add the embedded assertions and covers.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_periodic,
  input  logic [WIDTH-1:0] i_cmp,
  output logic [WIDTH-1:0] o_q,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cmp;
  logic             r_per;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_inc;
  logic             w_clr;
  logic             w_en;
  logic             w_hit;
  logic             w_adv;
  logic             w_start_ok;
  logic             w_start_err;

  assign w_q_inc     = w_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_start_ok  = (r_state == IDLE) && !i_stop && i_start && (i_cmp != '0);
  assign w_start_err = (r_state == IDLE) && !i_stop && i_start && (i_cmp == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_clr = 1'b0;
    w_en  = 1'b0;
    w_hit = 1'b0;
    w_adv = 1'b0;
    case (r_state)
      IDLE:       w_clr = i_stop || w_start_ok;
      RUN, PAUSE: begin
        if (i_stop)        w_clr = 1'b1;
        else if (!i_pause) w_adv = 1'b1;
      end
      default:    w_clr = 1'b1;
    endcase
    // Sitting at cmp while advancing only happens in periodic mode: reload 0.
    if (w_adv) begin
      if (w_q == r_cmp) begin
        w_clr = 1'b1;
      end else begin
        w_en  = 1'b1;
        w_hit = (w_q_inc == r_cmp);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_cmp   <= '0;
      r_per   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_hit;
      r_err  <= w_start_err;
      case (r_state)
        IDLE: if (w_start_ok) begin
          r_cmp   <= i_cmp;
          r_per   <= i_periodic;
          r_state <= RUN;
        end
        RUN, PAUSE: begin
          if (i_stop)              r_state <= IDLE;
          else if (i_pause)        r_state <= PAUSE;
          else if (w_hit && !r_per) r_state <= IDLE;
          else                     r_state <= RUN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  timer_cnt #(.WIDTH(WIDTH)) u_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_q    (w_q)
  );

  assign o_q     = w_q;
  assign o_state = r_state;
  assign o_busy  = (r_state != IDLE);
  assign o_done  = r_done;
  assign o_err   = r_err;

`ifdef TIMER_CTRL_FORMAL_EN
  default clocking cb_formal @(posedge i_clk); endclocking
  default disable iff (!i_rstn);

  a_q_le_cmp:   assert property (o_busy |-> (o_q <= r_cmp));
  a_done_once:  assert property (o_done |=> !o_done);
  a_stop:       assert property (i_stop |=> (o_q == '0 && !o_busy));
  a_done_match: assert property (o_done |-> (o_q == r_cmp));
  a_state_ok:   assert property (o_state != 2'd3);

  c_reload:     cover property (r_state == RUN && r_per && w_q == r_cmp && !i_stop && !i_pause);
  c_pause:      cover property (r_state == RUN && i_pause && !i_stop);
`else
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural reference model and per-cycle compare.
module tb_timer_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] cmp = '0;

  logic [W-1:0] q;
  logic [1:0]   st;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_stop     (stop),
    .i_pause    (pause),
    .i_periodic (periodic),
    .i_cmp      (cmp),
    .o_q        (q),
    .o_state    (st),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a running flag, a paused flag and an integer count.
  int unsigned m_q = 0;
  int unsigned m_cmp = 0;
  bit m_busy = 0, m_paused = 0, m_per = 0, m_done = 0, m_err = 0;
  bit cmp_on = 0;

  always @(posedge clk) begin : model
    int unsigned nq, ncmp;
    bit nb, np, nper, nd, ne;
    nq = m_q; ncmp = m_cmp; nb = m_busy; np = m_paused; nper = m_per;
    nd = 0; ne = 0;
    if (!rstn) begin
      nq = 0; ncmp = 0; nb = 0; np = 0; nper = 0;
    end else if (!m_busy) begin
      if (stop) nq = 0;
      else if (start && cmp == 0) ne = 1;
      else if (start) begin
        ncmp = cmp; nper = periodic; nq = 0; nb = 1; np = 0;
      end
    end else if (stop) begin
      nb = 0; np = 0; nq = 0;
    end else if (pause) begin
      np = 1;
    end else begin
      np = 0;
      if (m_q == m_cmp) nq = 0;
      else begin
        nq = m_q + 1;
        if (nq == m_cmp) begin
          nd = 1;
          if (!m_per) nb = 0;
        end
      end
    end
    m_q <= nq; m_cmp <= ncmp; m_busy <= nb; m_paused <= np; m_per <= nper;
    m_done <= nd; m_err <= ne;
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_q",     int'(q),    int'(m_q));
      check("model_state", int'(st),   !m_busy ? 0 : (m_paused ? 2 : 1));
      check("model_busy",  int'(busy), int'(m_busy));
      check("model_done",  int'(done), int'(m_done));
      check("model_err",   int'(err),  int'(m_err));
    end
  end

  initial begin
    step(); step();
    check("rst_q", int'(q), 0);
    check("rst_state", int'(st), 0);
    check("rst_done", int'(done), 0);
    rstn = 1'b1;
    cmp_on = 1'b1;
    step();

    // One-shot, cmp=3
    cmp = 3; periodic = 0; start = 1;
    step(); start = 0;
    check("t1_q0", int'(q), 0); check("t1_run", int'(st), 1);
    step(); check("t1_q1", int'(q), 1);
    step(); check("t1_q2", int'(q), 2);
    step(); check("t1_q3", int'(q), 3); check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    step(); check("t1_hold", int'(q), 3); check("t1_done_off", int'(done), 0);

    // Start with cmp=0: error pulse, count untouched; then stop in IDLE clears
    cmp = 0; start = 1;
    step(); start = 0;
    check("t5_err", int'(err), 1); check("t5_idle", int'(st), 0); check("t5_q", int'(q), 3);
    step(); check("t5_err_off", int'(err), 0);
    stop = 1; step(); stop = 0;
    check("idle_stop_q", int'(q), 0);

    // Periodic, cmp=2
    cmp = 2; periodic = 1; start = 1;
    step(); start = 0; periodic = 0;
    check("t2_q0", int'(q), 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("t2_q", int'(q), k % 3);
      check("t2_done", int'(done), (k % 3 == 2) ? 1 : 0);
    end
    stop = 1; step(); stop = 0;
    check("t2_stop", int'(st), 0);

    // Pause for 4 cycles at q=2, cmp=5
    cmp = 5; start = 1;
    step(); start = 0;
    step(); step(); check("t3_q2", int'(q), 2);
    pause = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_pq", int'(q), 2); check("t3_pst", int'(st), 2);
    end
    pause = 0;
    step(); check("t3_q3", int'(q), 3); check("t3_run", int'(st), 1);
    step(); check("t3_q4", int'(q), 4);
    step(); check("t3_q5", int'(q), 5); check("t3_done", int'(done), 1);

    // Stop and pause together at q=4
    cmp = 9; start = 1;
    step(); start = 0;
    for (int k = 0; k < 4; k++) step();
    check("t4_q4", int'(q), 4);
    stop = 1; pause = 1;
    step(); stop = 0; pause = 0;
    check("t4_q", int'(q), 0); check("t4_idle", int'(st), 0); check("t4_done", int'(done), 0);

    // Start ignored while running; original cmp=4 still governs
    cmp = 4; start = 1;
    step(); start = 0;
    step(); check("t5b_q1", int'(q), 1);
    cmp = 7; start = 1;
    step(); start = 0;
    check("t5b_q2", int'(q), 2); check("t5b_run", int'(st), 1);
    step(); step();
    check("t5b_q4", int'(q), 4); check("t5b_done", int'(done), 1); check("t5b_idle", int'(busy), 0);

    // Reset mid-run at q=7
    cmp = 20; start = 1;
    step(); start = 0;
    for (int k = 0; k < 7; k++) step();
    check("t6_q7", int'(q), 7);
    rstn = 0; step(); rstn = 1;
    check("t6_q", int'(q), 0); check("t6_idle", int'(st), 0); check("t6_done", int'(done), 0);
    step();

    // All-ones compare in periodic mode reloads 0
    cmp = 8'hFF; periodic = 1; start = 1;
    step(); start = 0; periodic = 0;
    for (int k = 0; k < 255; k++) step();
    check("t7_qmax", int'(q), 255); check("t7_done", int'(done), 1);
    step();
    check("t7_reload", int'(q), 0); check("t7_run", int'(st), 1); check("t7_done_off", int'(done), 0);
    stop = 1; step(); stop = 0;
    step();

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
